logistic_orbit_gen: RTL

Fixed-point logistic-map orbit generator. Sits directly upstream of the `logistic_snd` oscillator bank and supplies the iterate values that set its oscillator pitches. For each orbit it iterates x ← r·x·(1−x) with a bit-serial multiplier, discards a warm-up prefix, then streams N_OUT iterates over a valid/ready handshake. After each completed orbit, r advances by R_INC.

---
 rtl/logistic_orbit_gen_pkg.sv | 16 +
 rtl/logistic_orbit_gen_if.sv | 26 ++
 rtl/logistic_orbit_gen_seq_mul.sv | 39 +++
 rtl/logistic_orbit_gen.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/logistic_orbit_gen_pkg.sv
// Shared types and Q-format constants for the logistic-map blocks.
// Also used by the downstream oscillator bank.
package logistic_orbit_gen_pkg;

    localparam int unsigned FRAC_W    = 16;
    localparam int unsigned R_MIN_DEF = 3 << FRAC_W;
    localparam int unsigned R_MAX_DEF = (4 << FRAC_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_A,
        ST_MUL_B,
        ST_OUT
    } orbit_st_e;

endpackage

// File: rtl/logistic_orbit_gen_if.sv
// Iterate stream from the orbit generator to its consumer.
// Valid/ready handshake, one Q0.FRAC iterate per transfer.
interface logistic_orbit_gen_if
    import logistic_orbit_gen_pkg::*;
#(
    parameter int FRAC = FRAC_W
);
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [FRAC-1:0] x_out;

    modport master (
        output out_valid,
        output out_last,
        output x_out,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_last,
        input  x_out,
        output out_ready
    );
endinterface

// File: rtl/logistic_orbit_gen_seq_mul.sv
// Bit-serial shift-add multiplier, LSB-first over b, result (a*b)>>FRAC.
// p_o previews the accumulator after the current step.
module logistic_orbit_gen_seq_mul #(
    parameter int FRAC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [FRAC+1:0] a_i,
    input  logic [FRAC-1:0] b_i,
    output logic [FRAC+1:0] p_o
);
    localparam int AW = FRAC + 2;

    logic [AW-1:0]   a_q;
    logic [AW-1:0]   acc_q;
    logic [FRAC-1:0] b_q;
    logic [AW:0]     addend;

    // Dropping the LSB each step makes the final value a truncated product.
    assign addend = b_q[0] ? {1'b0, a_q} : '0;
    assign p_o    = AW'(({1'b0, acc_q} + addend) >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (load_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= '0;
        end else if (step_i) begin
            acc_q <= p_o;
            b_q   <= b_q >> 1;
        end
    end
endmodule

// File: rtl/logistic_orbit_gen.sv
// Logistic-map orbit generator: x <- r*x*(1-x), warm-up, then N_OUT iterates.
// r advances by R_INC after every completed orbit and wraps to R_MIN.
module logistic_orbit_gen
    import logistic_orbit_gen_pkg::*;
#(
    parameter int          FRAC   = FRAC_W,
    parameter int          N_OUT  = 8,
    parameter int          WARMUP = 64,
    parameter int unsigned R_MIN  = R_MIN_DEF,
    parameter int unsigned R_MAX  = R_MAX_DEF,
    parameter int unsigned R_INC  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic [FRAC+1:0]       r_out,
    logistic_orbit_gen_if.master  ob
);
    localparam int RW = FRAC + 2;
    localparam int CW = $clog2(FRAC);
    localparam int IW = $clog2(WARMUP + N_OUT + 1);

    localparam logic [RW-1:0]   RMIN  = RW'(R_MIN);
    localparam logic [RW:0]     RMAX  = (RW+1)'(R_MAX);
    localparam logic [RW:0]     RINC  = (RW+1)'(R_INC);
    localparam logic [FRAC-1:0] HALF  = {1'b1, {(FRAC-1){1'b0}}};
    localparam logic [CW-1:0]   CLAST = CW'(FRAC - 1);
    localparam logic [IW-1:0]   IWARM = IW'(WARMUP);
    localparam logic [IW-1:0]   ILAST = IW'(WARMUP + N_OUT - 1);

    orbit_st_e       st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   it_q, it_d, it_nx;
    logic [FRAC-1:0] x_q, x_d;
    logic [RW-1:0]   r_q, r_d;
    logic            vld_q, vld_d;
    logic            last_q, last_d;

    logic            ld, stp;
    logic [RW-1:0]   ma, mp;
    logic [FRAC-1:0] mb, psat;
    logic [RW:0]     rsum;

    logistic_orbit_gen_seq_mul #(.FRAC(FRAC)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(ld),
        .step_i(stp),
        .a_i   (ma),
        .b_i   (mb),
        .p_o   (mp)
    );

    assign it_nx = it_q + 1'b1;
    assign psat  = (|mp[RW-1:FRAC]) ? '1 : mp[FRAC-1:0];
    assign rsum  = {1'b0, r_q} + RINC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            it_q   <= '0;
            x_q    <= '0;
            r_q    <= RMIN;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            it_q   <= it_d;
            x_q    <= x_d;
            r_q    <= r_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    // ~x stands in for 1-x; the multiplier is reloaded on every phase change.
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        it_d   = it_q;
        x_d    = x_q;
        r_d    = r_q;
        vld_d  = vld_q;
        last_d = last_q;
        ld     = 1'b0;
        stp    = 1'b0;
        ma     = {2'b00, x_q};
        mb     = ~x_q;
        unique case (st_q)
            ST_IDLE: begin
                if (start) begin
                    st_d  = ST_MUL_A;
                    x_d   = HALF;
                    it_d  = '0;
                    cnt_d = '0;
                    ld    = 1'b1;
                    ma    = {2'b00, HALF};
                    mb    = ~HALF;
                end
            end
            ST_MUL_A: begin
                stp   = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CLAST) begin
                    st_d  = ST_MUL_B;
                    cnt_d = '0;
                    ld    = 1'b1;
                    ma    = r_q;
                    mb    = mp[FRAC-1:0];
                end
            end
            ST_MUL_B: begin
                stp   = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CLAST) begin
                    cnt_d = '0;
                    x_d   = psat;
                    it_d  = it_nx;
                    if (it_nx <= IWARM) begin
                        st_d = ST_MUL_A;
                        ld   = 1'b1;
                        ma   = {2'b00, psat};
                        mb   = ~psat;
                    end else begin
                        st_d   = ST_OUT;
                        vld_d  = 1'b1;
                        last_d = (it_q == ILAST);
                    end
                end
            end
            ST_OUT: begin
                if (ob.out_ready) begin
                    vld_d  = 1'b0;
                    last_d = 1'b0;
                    if (last_q) begin
                        st_d = ST_IDLE;
                        r_d  = (rsum > RMAX) ? RMIN : rsum[RW-1:0];
                    end else begin
                        st_d = ST_MUL_A;
                        ld   = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        busy         = (st_q != ST_IDLE);
        r_out        = r_q;
        ob.out_valid = vld_q;
        ob.out_last  = last_q;
        ob.x_out     = x_q;
    end
endmodule
